// File: rtl/vga_capture.sv
// vga_capture: one-shot VGA frame grabber. Consumes pixel/sync timing and writes the
// decimated active picture into a 24-bit framebuffer RAM through its d/adr/we port.
// Optional feature macro: CAPTURE_SUM_EN (frame_sum accumulates every stored word).
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM    = 2,
    parameter int ADR_W    = 17
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             vid_hs_n,
    input  logic             vid_vs_n,
    input  logic             vid_blank_n,
    input  logic [7:0]       vid_r,
    input  logic [7:0]       vid_g,
    input  logic [7:0]       vid_b,
    input  logic             arm,
    output logic [ADR_W-1:0] fb_adr,
    output logic [23:0]      fb_d,
    output logic             fb_we,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow,
    output logic [31:0]      frame_sum
);
    localparam int XW       = $clog2(H_ACTIVE + 1);
    localparam int YW       = $clog2(V_ACTIVE + 1);
    localparam int FB_WORDS = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);
    localparam logic [XW-1:0]  X_MAX   = XW'(H_ACTIVE);
    localparam logic [YW-1:0]  Y_MAX   = YW'(V_ACTIVE);
    localparam logic [ADR_W:0] ADR_END = (ADR_W + 1)'(FB_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [ADR_W-1:0] fb_adr_q, fb_adr_d;
    logic [23:0]      fb_d_q, fb_d_d;
    logic             fb_we_q, fb_we_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    logic             hs_prev_q, hs_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic             blank_prev_q, blank_prev_d;

    logic hs_fall, vs_fall, blank_fall, arm_acc, keep, adr_full;
    logic [23:0] rgb;

    // Edges only exist on strobe cycles; prev samples idle high so reset never fakes an edge.
    assign hs_fall    = pix_en & hs_prev_q & ~vid_hs_n;
    assign vs_fall    = pix_en & vs_prev_q & ~vid_vs_n;
    assign blank_fall = pix_en & blank_prev_q & ~vid_blank_n;
    assign arm_acc    = (state_q == IDLE) && arm;
    assign keep       = (DECIM == 1) || (!x_q[0] && !y_q[0]);
    assign adr_full   = ({1'b0, adr_q} >= ADR_END);
    assign rgb        = {vid_r, vid_g, vid_b};

    // Next-state: FSM, raster counters, store decision and registered RAM port.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        adr_d        = adr_q;
        fb_adr_d     = fb_adr_q;
        fb_d_d       = fb_d_q;
        fb_we_d      = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        hs_prev_d    = hs_prev_q;
        vs_prev_d    = vs_prev_q;
        blank_prev_d = blank_prev_q;
        if (pix_en) begin
            hs_prev_d    = vid_hs_n;
            vs_prev_d    = vid_vs_n;
            blank_prev_d = vid_blank_n;
        end
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = WAIT_VS;
                    overflow_d = 1'b0;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d  = CAPTURE;
                    x_d      = '0;
                    y_d      = '0;
                    adr_d    = '0;
                    fb_adr_d = '0;
                end
            end
            CAPTURE: begin
                if (pix_en) begin
                    if (vid_blank_n) begin
                        if (x_q >= X_MAX || y_q >= Y_MAX) begin
                            overflow_d = 1'b1;
                        end else if (keep) begin
                            if (adr_full) begin
                                overflow_d = 1'b1;
                            end else begin
                                fb_we_d  = 1'b1;
                                fb_d_d   = rgb;
                                fb_adr_d = adr_q;
                                adr_d    = adr_q + ADR_W'(1);
                            end
                        end
                        if (x_q != X_MAX) x_d = x_q + XW'(1);
                    end
                    // y saturates too so an over-long frame can never wrap into stores
                    if (blank_fall && x_q != '0 && y_q != Y_MAX) y_d = y_q + YW'(1);
                    if (hs_fall) x_d = '0;
                    // the pixel on this strobe was already handled above
                    if (vs_fall) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT_VS) || (state_d == CAPTURE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            adr_q        <= '0;
            fb_adr_q     <= '0;
            fb_d_q       <= '0;
            fb_we_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            blank_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            adr_q        <= adr_d;
            fb_adr_q     <= fb_adr_d;
            fb_d_q       <= fb_d_d;
            fb_we_q      <= fb_we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            blank_prev_q <= blank_prev_d;
        end
    end

    assign fb_adr     = fb_adr_q;
    assign fb_d       = fb_d_q;
    assign fb_we      = fb_we_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

`ifdef CAPTURE_SUM_EN
    logic [31:0] sum_q, sum_d;

    // Checksum restarts on an accepted arm and adds each word as it is stored.
    always_comb begin
        sum_d = sum_q;
        if (arm_acc)      sum_d = 32'h0;
        else if (fb_we_d) sum_d = sum_q + {8'h0, rgb};
    end

    // Checksum register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) sum_q <= 32'h0;
        else       sum_q <= sum_d;
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = 32'h0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives small-geometry VGA frames and checks the framebuffer writes
// against a raster model of which pixels land at which address.
module tb_vga_capture;
    localparam int H_A = 16, V_A = 12, DEC = 2, AW = 6;
    localparam int HFP = 2, HSW = 3, HBP = 3, VFP = 1, VSW = 2, VBP = 2;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1, pix_en = 1'b0, arm = 1'b0;
    logic          vid_hs_n = 1'b1, vid_vs_n = 1'b1, vid_blank_n = 1'b0;
    logic [7:0]    vid_r = 8'h0, vid_g = 8'h0, vid_b = 8'h0;
    logic [AW-1:0] fb_adr;
    logic [23:0]   fb_d;
    logic          fb_we, busy, frame_done, overflow;
    logic [31:0]   frame_sum;

    typedef struct {int adr; logic [23:0] dat;} wr_t;
    wr_t         exp_q[$];
    logic [31:0] m_sum = 32'h0;
    logic [23:0] wr_mem [0:63];
    int checks = 0, failures = 0;
    int wr_total = 0, done_cnt = 0, last_adr = -1;

    vga_capture #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .DECIM(DEC), .ADR_W(AW)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pix_en(pix_en),
        .vid_hs_n(vid_hs_n), .vid_vs_n(vid_vs_n), .vid_blank_n(vid_blank_n),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .arm(arm),
        .fb_adr(fb_adr), .fb_d(fb_d), .fb_we(fb_we), .busy(busy),
        .frame_done(frame_done), .overflow(overflow), .frame_sum(frame_sum)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every write is compared against the next expected (address, colour) pair.
    always @(negedge CLOCK_50) begin
        if (fb_we) begin
            wr_t e;
            wr_total++;
            last_adr = int'(fb_adr);
            wr_mem[fb_adr] = fb_d;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write adr=%0d data=%h required=no write", fb_adr, fb_d);
            end else begin
                e = exp_q.pop_front();
                check("wr_adr", 32'(fb_adr), e.adr);
                check("wr_data", 32'(fb_d), 32'(e.dat));
            end
        end
        if (frame_done) done_cnt++;
    end

    function automatic logic [23:0] colour(input int mode, input int x, input int y);
        logic [7:0] xb, yb;
        xb = 8'(x);
        yb = 8'(y);
        case (mode)
            0:       return {xb, yb, xb ^ yb};
            1:       return 24'h123456;
            default: return 24'($urandom);
        endcase
    endfunction

    // One pixel strobe followed by idle cycles (sometimes 3) with optional stray arms.
    task automatic tick(input bit hs, input bit vs, input bit bl, input logic [23:0] c,
                        input bit a, input bit gaps, input bit barms);
        int g;
        vid_hs_n = hs; vid_vs_n = vs; vid_blank_n = bl;
        {vid_r, vid_g, vid_b} = c;
        arm = a;
        pix_en = 1'b1;
        @(posedge CLOCK_50); #1;
        pix_en = 1'b0;
        arm = 1'b0;
        g = (gaps && $urandom_range(0, 3) == 0) ? 3 : 1;
        for (int i = 0; i < g; i++) begin
            if (barms && i == 0 && $urandom_range(0, 5) == 0) arm = 1'b1;
            @(posedge CLOCK_50); #1;
            arm = 1'b0;
        end
    endtask

    // Frame = nl active lines, porches, vsync at the end. capt: this frame's pixels are stored.
    task automatic frame(input int nl, input int na, input int mode, input bit do_arm,
                         input bit capt, input bit gaps, input bit barms, input int abort_ln);
        int vt, ht;
        bit hs, vs, bl;
        logic [23:0] c;
        vt = nl + VFP + VSW + VBP;
        ht = na + HFP + HSW + HBP;
        if (do_arm) m_sum = 32'h0;
        for (int ln = 0; ln < vt; ln++) begin
            for (int px = 0; px < ht; px++) begin
                if (ln == abort_ln && px == 0) begin
                    reset = 1'b1;
                    @(posedge CLOCK_50); #1;
                    check("abort_we", 32'(fb_we), 0);
                    check("abort_busy", 32'(busy), 0);
                    check("abort_done", 32'(frame_done), 0);
                    reset = 1'b0;
                    return;
                end
                bl = (ln < nl) && (px < na);
                hs = !(px >= na + HFP && px < na + HFP + HSW);
                vs = !(ln >= nl + VFP && ln < nl + VFP + VSW);
                c  = colour(mode, px, ln);
                if (capt && bl && ln < V_A && px < H_A && ln % 2 == 0 && px % 2 == 0) begin
                    wr_t e;
                    e.adr = (ln / 2) * (H_A / 2) + px / 2;
                    e.dat = c;
                    exp_q.push_back(e);
                    m_sum += {8'h0, c};
                end
                tick(hs, vs, bl, c, do_arm && ln == 0 && px == 0, gaps, barms && ln < nl + VFP);
                if (do_arm && ln == 0 && px == 0) begin
                    check("arm_ovf_clr", 32'(overflow), 0);
                    check("arm_busy", 32'(busy), 1);
                end
            end
        end
    endtask

    task automatic end_check(input string tag, input int nwr, input int last, input bit ovf,
                             input int db, input int wb);
        check({tag, "_done"}, done_cnt - db, 1);
        check({tag, "_writes"}, wr_total - wb, nwr);
        check({tag, "_last_adr"}, last_adr, last);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        check({tag, "_busy"}, 32'(busy), 0);
`ifdef CAPTURE_SUM_EN
        check({tag, "_sum"}, frame_sum, m_sum);
`else
        check({tag, "_sum"}, frame_sum, 0);
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int db, wb;
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(posedge CLOCK_50); #1;
        check("rst_adr", 32'(fb_adr), 0);
        check("rst_d", 32'(fb_d), 0);
        check("rst_we", 32'(fb_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_sum", frame_sum, 0);

        // full frame, x^y pattern
        db = done_cnt; wb = wr_total;
        frame(V_A, H_A, 0, 1, 0, 0, 0, -1);
        frame(V_A, H_A, 0, 0, 1, 0, 0, -1);
        end_check("t1", 48, 47, 0, db, wb);
        check("t1_adr0", 32'(wr_mem[0]), 32'h000000);
        check("t1_adr7", 32'(wr_mem[7]), 32'h0E000E);
        check("t1_adr8", 32'(wr_mem[8]), 32'h000202);
        check("t1_adr47", 32'(wr_mem[47]), 32'h0E0A04);

        // constant colour
        db = done_cnt; wb = wr_total;
        frame(V_A, H_A, 1, 1, 0, 0, 0, -1);
        frame(V_A, H_A, 1, 0, 1, 0, 0, -1);
        end_check("t2", 48, 47, 0, db, wb);
        check("t2_adr7", 32'(wr_mem[7]), 32'h123456);
`ifdef CAPTURE_SUM_EN
        check("t2_sum_lit", frame_sum, 32'h0369D020);
`endif

        // over-wide lines
        db = done_cnt; wb = wr_total;
        frame(V_A, H_A, 2, 1, 0, 0, 0, -1);
        frame(V_A, H_A + 2, 2, 0, 1, 0, 0, -1);
        end_check("t3", 48, 47, 1, db, wb);

        // reset mid-capture, quiet frame, then a clean re-armed capture
        db = done_cnt; wb = wr_total;
        frame(V_A, H_A, 2, 1, 0, 0, 0, -1);
        frame(V_A, H_A, 2, 0, 1, 0, 0, 5);
        check("t4_writes", wr_total - wb, 24);
        check("t4_last_adr", last_adr, 23);
        check("t4_pending", exp_q.size(), 0);
        frame(V_A, H_A, 2, 0, 0, 0, 0, -1);
        check("t4_quiet_writes", wr_total - wb, 24);
        check("t4_no_done", done_cnt - db, 0);
        db = done_cnt; wb = wr_total;
        frame(V_A, H_A, 2, 1, 0, 0, 0, -1);
        frame(V_A, H_A, 2, 0, 1, 0, 0, -1);
        end_check("t4b", 48, 47, 0, db, wb);

        // strobe gaps and stray arms while busy
        db = done_cnt; wb = wr_total;
        frame(V_A, H_A, 2, 1, 0, 1, 1, -1);
        frame(V_A, H_A, 2, 0, 1, 1, 1, -1);
        end_check("t5", 48, 47, 0, db, wb);

        // short frame
        db = done_cnt; wb = wr_total;
        frame(V_A, H_A, 0, 1, 0, 0, 0, -1);
        frame(6, H_A, 0, 0, 1, 0, 0, -1);
        end_check("t6", 24, 23, 0, db, wb);

        repeat (10) @(posedge CLOCK_50);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
